// File: rtl/lsu_stream_reader.sv
// lsu_stream_reader
// Sweeps one full frame out of the LSU through its registered read port.
// The beats are presented on an AXI-Stream master that honours backpressure.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   start           begin a frame sweep (sampled only when idle)
//   base_ptr        first LSU address, captured on an accepted start
//   busy            high from the cycle after an accepted start through done
//   done            one-cycle pulse after the last beat's handshake
//   read_enable     LSU read strobe
//   read_ptr        LSU read address
//   read_data       LSU read data, valid one cycle after read_enable
//   m_axis_*        stream master (tdata/tvalid/tready/tlast)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing LSU reads, streaming returned beats
// DRAIN | all reads issued, streaming the remaining beats

module lsu_stream_reader #(
   parameter int IMAGE_DIM  = 512,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_ptr,
   output logic                  busy,
   output logic                  done,
   output logic                  read_enable,
   output logic [ADDR_WIDTH-1:0] read_ptr,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam int NUM_BEATS = IMAGE_DIM * IMAGE_DIM / 16;
   localparam int CNT_W     = $clog2(NUM_BEATS) + 1;
   localparam logic [CNT_W-1:0] BEATS     = CNT_W'(NUM_BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]      issue_cnt;
   logic [CNT_W-1:0]      out_cnt;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_idx;
   logic                  rd_idx;
   logic [1:0]            occ;
   logic                  pop;
   logic                  push;
   logic [2:0]            pending;

   assign pop  = (occ != 2'd0) && m_axis_tready;
   assign push = inflight;

   // Beats already committed to the FIFO once this cycle's pop is taken out.
   // A new read is allowed only if its return is guaranteed a free slot.
   assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign read_enable   = (state == RUN) && (issue_cnt < BEATS) && (pending < 3'd2);
   assign read_ptr      = addr_q;
   assign m_axis_tdata  = fifo_mem[rd_idx];
   assign m_axis_tvalid = (occ != 2'd0);
   assign m_axis_tlast  = m_axis_tvalid && (out_cnt == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         addr_q      <= '0;
         issue_cnt   <= '0;
         out_cnt     <= '0;
         inflight    <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_idx      <= 1'b0;
         rd_idx      <= 1'b0;
         occ         <= 2'd0;
      end else begin
         inflight <= read_enable;
         done     <= 1'b0;

         if (push) begin
            fifo_mem[wr_idx] <= read_data;
            wr_idx           <= ~wr_idx;
         end
         if (pop) begin
            rd_idx  <= ~rd_idx;
            out_cnt <= out_cnt + 1'b1;
         end
         occ <= occ + {1'b0, push} - {1'b0, pop};

         // The address stops on the last issued location so read_ptr holds
         // once the sweep has been fully issued.
         if (read_enable) begin
            issue_cnt <= issue_cnt + 1'b1;
            if (issue_cnt != LAST_BEAT) begin
               addr_q <= addr_q + 1'b1;
            end
         end

         if (pop && (out_cnt == LAST_BEAT)) begin
            done <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  addr_q    <= base_ptr;
                  issue_cnt <= '0;
                  out_cnt   <= '0;
               end
            end
            RUN: begin
               if (issue_cnt == BEATS) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_cnt == BEATS) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_stream_reader.sv
// Bench for lsu_stream_reader with a 16x16 image (16 beats per frame).
// A frame-level model predicts every output each cycle from issue/pop
// bookkeeping; directed phases pin latency, wrap, stall, reset and start
// filtering with literal values.

module tb_lsu_stream_reader;

   localparam int IMAGE_DIM  = 16;
   localparam int DATA_WIDTH = 128;
   localparam int ADDR_WIDTH = 14;
   localparam int NB         = 16;
   localparam int LSU_SIZE   = 1 << ADDR_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_ptr;
   logic                  busy;
   logic                  done;
   logic                  read_enable;
   logic [ADDR_WIDTH-1:0] read_ptr;
   logic [DATA_WIDTH-1:0] read_data;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   lsu_stream_reader #(
      .IMAGE_DIM  (IMAGE_DIM),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_ptr      (base_ptr),
      .busy          (busy),
      .done          (done),
      .read_enable   (read_enable),
      .read_ptr      (read_ptr),
      .read_data     (read_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   always #5 clk = ~clk;

   // LSU with a registered read port
   logic [DATA_WIDTH-1:0] lsu_mem [LSU_SIZE];
   always @(posedge clk) begin
      if (read_enable) read_data <= lsu_mem[read_ptr];
   end

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // frame model
   bit                    model_ok = 1'b0;
   bit                    m_busy, m_run, m_done;
   logic [ADDR_WIDTH-1:0] m_base;
   int                    iss_k, out_k;
   int                    issue_time [NB];
   bit                    prev_stall;
   logic [DATA_WIDTH-1:0] prev_tdata;

   // observations of the DUT for the directed literal checks
   int                    rec_start, rec_first_tv, rec_done_cyc, rec_busy_cnt, rec_dones;
   int                    rec_reads, rec_beats, rec_tlast_cnt, rec_tlast_beat, rec_accepts;
   logic [ADDR_WIDTH-1:0] rp_log   [NB];
   logic [DATA_WIDTH-1:0] beat_log [NB];

   task automatic clear_rec();
      rec_start = -100; rec_first_tv = -1; rec_done_cyc = -1; rec_busy_cnt = 0;
      rec_dones = 0; rec_reads = 0; rec_beats = 0; rec_tlast_cnt = 0;
      rec_tlast_beat = -1; rec_accepts = 0;
      for (int i = 0; i < NB; i++) begin
         rp_log[i]   = '0;
         beat_log[i] = '0;
      end
   endtask

   always @(negedge clk) begin : cmp
      int                    avail;
      bit                    tv_e, pop_e, re_e, done_next, was_busy;
      logic [DATA_WIDTH-1:0] exp_data;
      logic [ADDR_WIDTH-1:0] exp_ptr;
      cyc++;
      if (model_ok) begin
         // a beat reaches the FIFO two cycles after its read was issued
         avail = 0;
         for (int k = 0; k < iss_k; k++) if (issue_time[k] <= cyc - 2) avail++;
         avail    = avail - out_k;
         tv_e     = (avail > 0);
         pop_e    = tv_e && m_axis_tready;
         re_e     = m_run && (iss_k < NB) && ((iss_k - out_k - int'(pop_e)) < 2);
         exp_data = lsu_mem[m_base + 14'(out_k)];
         exp_ptr  = m_base + 14'(iss_k);

         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("read_enable", read_enable, re_e);
         if (re_e) chk("read_ptr", read_ptr, exp_ptr);
         chk("tvalid", m_axis_tvalid, tv_e);
         if (tv_e) chk("tdata", m_axis_tdata, exp_data);
         chk("tlast", m_axis_tlast, tv_e && (out_k == NB - 1));
         if (prev_stall) begin
            chk("stall_tvalid", m_axis_tvalid, 1'b1);
            chk("stall_tdata", m_axis_tdata, prev_tdata);
         end

         if (busy) rec_busy_cnt++;
         if (done) begin
            rec_dones++;
            rec_done_cyc = cyc;
         end
         if (m_axis_tvalid && rec_first_tv < 0) rec_first_tv = cyc;
         if (read_enable) begin
            if (rec_reads < NB) rp_log[rec_reads] = read_ptr;
            rec_reads++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (rec_beats < NB) beat_log[rec_beats] = m_axis_tdata;
            if (m_axis_tlast) begin
               rec_tlast_cnt++;
               rec_tlast_beat = rec_beats;
            end
            rec_beats++;
         end

         done_next = pop_e && (out_k == NB - 1);
         if (re_e) begin
            issue_time[iss_k] = cyc;
            iss_k++;
         end
         if (pop_e) out_k++;
         was_busy = m_busy;
         if (m_done) begin
            m_busy = 1'b0;
            m_run  = 1'b0;
         end
         if (!was_busy && start) begin
            m_busy    = 1'b1;
            m_run     = 1'b1;
            m_base    = base_ptr;
            iss_k     = 0;
            out_k     = 0;
            rec_start = cyc;
            rec_accepts++;
         end
         m_done = done_next;
      end
      prev_stall = model_ok && !rst && m_axis_tvalid && !m_axis_tready;
      prev_tdata = m_axis_tdata;
      if (rst) begin
         model_ok   = 1'b1;
         m_busy     = 1'b0;
         m_run      = 1'b0;
         m_done     = 1'b0;
         iss_k      = 0;
         out_k      = 0;
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [ADDR_WIDTH-1:0] base);
      base_ptr = base;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_frame(input int max_cyc, input string name);
      int n = 0;
      while (rec_dones == 0 && n < max_cyc) begin
         step();
         n++;
      end
      if (rec_dones == 0) chk({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_ptr = '0; m_axis_tready = 1'b1;
      for (int i = 0; i < LSU_SIZE; i++) lsu_mem[i] = 128'(i);
      clear_rec();
      repeat (3) step();
      rst = 1'b0;
      step();

      // full-rate frame
      clear_rec();
      pulse_start(14'd0);
      wait_frame(100, "t1");
      chk("t1_first_tvalid_cycle", 128'(rec_first_tv - rec_start), 128'(3));
      chk("t1_done_cycle", 128'(rec_done_cyc - rec_start), 128'(19));
      chk("t1_busy_cycles", 128'(rec_busy_cnt), 128'(19));
      chk("t1_beats", 128'(rec_beats), 128'(16));
      chk("t1_tlast_count", 128'(rec_tlast_cnt), 128'(1));
      chk("t1_tlast_beat", 128'(rec_tlast_beat), 128'(15));
      chk("t1_beat0", beat_log[0], 128'd0);
      chk("t1_beat15", beat_log[15], 128'd15);
      chk("t1_busy_after", busy, 1'b0);

      // random 30% backpressure
      clear_rec();
      pulse_start(14'd0);
      begin : t2
         int n = 0;
         while (rec_dones == 0 && n < 300) begin
            m_axis_tready = ($urandom_range(0, 9) >= 3);
            step();
            n++;
         end
         if (rec_dones == 0) chk("t2_timeout", 1'b0, 1'b1);
      end
      m_axis_tready = 1'b1;
      chk("t2_beats", 128'(rec_beats), 128'(16));
      chk("t2_reads", 128'(rec_reads), 128'(16));
      for (int i = 0; i < NB; i++) chk("t2_beat_order", beat_log[i], 128'(i));

      // address wrap at the top of the LSU
      clear_rec();
      pulse_start(14'd16380);
      wait_frame(100, "t3");
      chk("t3_ptr0", rp_log[0], 14'd16380);
      chk("t3_ptr3", rp_log[3], 14'd16383);
      chk("t3_ptr4", rp_log[4], 14'd0);
      chk("t3_ptr15", rp_log[15], 14'd11);
      chk("t3_beat0", beat_log[0], 128'd16380);
      chk("t3_beat4", beat_log[4], 128'd0);

      // hold tready low from the start cycle for 20 cycles
      clear_rec();
      m_axis_tready = 1'b0;
      pulse_start(14'd5);
      repeat (19) step();
      chk("t4_reads_stalled", 128'(rec_reads), 128'(2));
      chk("t4_tvalid_stalled", m_axis_tvalid, 1'b1);
      chk("t4_tdata_stalled", m_axis_tdata, 128'd5);
      chk("t4_read_enable_stalled", read_enable, 1'b0);
      m_axis_tready = 1'b1;
      wait_frame(100, "t4");
      chk("t4_beats", 128'(rec_beats), 128'(16));
      chk("t4_beat15", beat_log[15], 128'd20);

      // reset while beat 7 is presented
      clear_rec();
      pulse_start(14'd0);
      begin : t5
         int n = 0;
         while (rec_beats < 7 && n < 50) begin
            step();
            n++;
         end
         if (rec_beats < 7) chk("t5_timeout", 1'b0, 1'b1);
      end
      chk("t5_beat7_head", m_axis_tdata, 128'd7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_done", done, 1'b0);
      chk("t5_rst_read_enable", read_enable, 1'b0);
      chk("t5_rst_read_ptr", read_ptr, 14'd0);
      chk("t5_rst_tdata", m_axis_tdata, 128'd0);
      chk("t5_rst_tvalid", m_axis_tvalid, 1'b0);
      chk("t5_rst_tlast", m_axis_tlast, 1'b0);
      repeat (5) step();
      chk("t5_no_done", 128'(rec_dones), 128'(0));
      clear_rec();
      pulse_start(14'd0);
      wait_frame(100, "t5");
      chk("t5_fresh_beats", 128'(rec_beats), 128'(16));
      chk("t5_fresh_beat7", beat_log[7], 128'd7);
      chk("t5_fresh_beat15", beat_log[15], 128'd15);

      // start while busy (cycle 5) and in the done cycle (cycle 19)
      clear_rec();
      pulse_start(14'd3);
      for (int c = 1; c < 25; c++) begin
         start = (c == 5 || c == 19);
         step();
      end
      start = 1'b0;
      chk("t6_accepts", 128'(rec_accepts), 128'(1));
      chk("t6_dones", 128'(rec_dones), 128'(1));
      chk("t6_done_cycle", 128'(rec_done_cyc - rec_start), 128'(19));
      chk("t6_busy_after", busy, 1'b0);

      // random frames: random data, bases, backpressure and stray starts
      for (int i = 0; i < LSU_SIZE; i++) lsu_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int f = 0; f < 6; f++) begin
         int d0;
         int n;
         d0 = rec_dones;
         n  = 0;
         pulse_start(14'($urandom));
         while (rec_dones == d0 && n < 300) begin
            m_axis_tready = ($urandom_range(0, 9) >= 3);
            start         = ($urandom_range(0, 7) == 0);
            base_ptr      = 14'($urandom);
            step();
            n++;
         end
         start = 1'b0;
         if (rec_dones == d0) chk("rand_timeout", 1'b0, 1'b1);
      end
      m_axis_tready = 1'b1;
      begin : drain
         int n = 0;
         while (m_busy && n < 100) begin
            step();
            n++;
         end
         if (m_busy) chk("drain_timeout", 1'b0, 1'b1);
      end
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_stream_reader.md
# lsu_stream_reader

Streaming read engine for the LSU line/frame buffer. On a start pulse it sweeps one full image (IMAGE_DIM×IMAGE_DIM pixels, 16 pixels per 128-bit beat) out of the LSU through its registered read port. It presents the beats on an AXI-Stream master with full backpressure support. It is the consumer end of the LSU write path and feeds the downstream filter/fusion stages.

## Interface
- IMAGE_DIM, 512, image width/height in pixels
- DATA_WIDTH, 128, beat width (16 pixels × 8 bit)
- ADDR_WIDTH, 14, LSU address width
- NUM_BEATS (localparam), IMAGE_DIM*IMAGE_DIM/16, beats per frame
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a frame sweep; sampled only in IDLE
- base_ptr  in  ADDR_WIDTH  first LSU address; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last beat's handshake
- read_enable  out  1  LSU read strobe
- read_ptr  out  ADDR_WIDTH  LSU read address
- read_data  in  DATA_WIDTH  LSU read data, valid 1 cycle after read_enable
- m_axis_tdata  out  DATA_WIDTH  stream beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  high on beat NUM_BEATS-1

## Operation
- FSM states are IDLE, RUN, DRAIN.
  - IDLE→RUN on start: latch base_ptr, clear issue and output counters.
  - RUN→DRAIN when issue count reaches NUM_BEATS.
  - DRAIN→IDLE when output count reaches NUM_BEATS. done pulses in the same cycle busy falls.
- Address generation: read_ptr = base_ptr + issue_cnt, modulo 2^ADDR_WIDTH. Wrap past the top of the LSU is legal and silent.
- Read return tracking: 1-bit in-flight flag = read_enable delayed one cycle. When the flag is set, read_data is pushed into a 2-entry output FIFO.
- Output FIFO: head drives m_axis_tdata. m_axis_tvalid = FIFO non-empty. Pop on tvalid && tready.
- Issue rule: in RUN, read_enable = (issue_cnt < NUM_BEATS) && (occupancy + inflight − pop < 2). The FIFO therefore never overflows, and no LSU data is ever dropped or re-read.
- tlast = tvalid && (out_cnt == NUM_BEATS−1).
- start while busy is ignored. start in the same cycle as done is also ignored. A new start is accepted from the cycle after done.
- Counters are log2(NUM_BEATS)+1 bits so that the terminal value NUM_BEATS is representable.

## Timing
- Reset values:
  - FSM = IDLE.
  - busy, done, read_enable, m_axis_tvalid, m_axis_tlast = 0.
  - read_ptr, m_axis_tdata = 0.
  - FIFO empty, in-flight flag = 0, counters = 0.
- rst mid-frame: on the next edge every output returns to its reset value, and any in-flight LSU data is discarded. No done pulse is produced.
- Latency: start sampled in cycle 0. busy and read_enable are asserted in cycle 1 with read_ptr=base_ptr. The first read_data is available in cycle 2, and m_axis_tvalid is asserted in cycle 3.
- Throughput: with tready held high, one beat per cycle, no bubbles. The last beat appears in cycle NUM_BEATS+2, and done is asserted in cycle NUM_BEATS+3.
- Backpressure: while tready=0, tdata, tvalid and tlast are held stable. read_enable deasserts within one cycle once the FIFO plus in-flight count reaches 2. Full rate resumes the cycle after tready returns.
- read_ptr is don't-care when read_enable=0, but it is held at its last value.

## Test plan
- Use IMAGE_DIM=16, so NUM_BEATS=16. Preload LSU[i]=i. Pulse start with base_ptr=0 and hold tready=1. Required: tvalid first in cycle 3, then beats 0..15 on consecutive cycles, tlast on beat 15 only, done in cycle 19, busy high in cycles 1–19.
- Same preload, with tready toggled by a pseudo-random pattern that is 30% low. Required: all 16 beats arrive in order with no loss or duplication, tdata stays stable while stalled, and read_enable never issues with occupancy+inflight=2 and no pop.
- base_ptr=2^14−4. Required: read_ptr sequence 16380..16383, 0..11, with stream data matching LSU contents at those addresses.
- Hold tready=0 from cycle 0 for 20 cycles. Required: exactly 2 reads issued, tvalid high with beat 0 held, then a clean resume.
- Assert rst at output beat 7 mid-frame. Required: all outputs are 0 the next cycle and no done. A fresh start then yields beats 0..15 correctly.
- Pulse start at cycle 5, and again in the done cycle. Required: both ignored, one frame only.
